// File: rtl/bram_input_1x1_loader_pkg.sv
// ---------------------------------------------------------------------------
// bram_input_1x1_loader_pkg
// Shared definitions for the 1x1-conv input feature-map buffer: loader state
// encoding, default geometry, and helpers that derive the BRAM address width
// and word width. The BRAM and the downstream read controller import the
// same package, so all three agree on geometry.
// ---------------------------------------------------------------------------
package bram_input_1x1_loader_pkg;

  // Loader FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FULL  = 2'd3
  } state_e;

  // Default geometry.
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_IN_CHANNELS = 3;
  localparam int DEF_IN_WIDTH    = 5;
  localparam int DEF_IN_HEIGHT   = 5;

  // Pixel address width: $clog2(width*height), never narrower than 1 bit.
  function automatic int addr_w(input int width, input int height);
    return (width * height > 1) ? $clog2(width * height) : 1;
  endfunction

  // Packed pixel word width.
  function automatic int word_w(input int data_width, input int channels);
    return data_width * channels;
  endfunction

  // Lane index width, never narrower than 1 bit.
  function automatic int lane_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/bram_input_1x1_loader_channel_packer.sv
// ---------------------------------------------------------------------------
// bram_input_1x1_loader_channel_packer
// Collects serial channel samples into one pixel word.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   beat_i     : a sample is transferred this cycle
//   lane_i     : lane (channel index) the sample belongs to
//   data_i     : the sample
//   word_o     : packed word including the current beat (combinational view)
//   word_done_o: current beat fills the last lane; word_o is complete
// Channel c occupies bits [(c+1)*DATA_WIDTH-1 -: DATA_WIDTH].
// ---------------------------------------------------------------------------
module bram_input_1x1_loader_channel_packer
  import bram_input_1x1_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int IN_CHANNELS = DEF_IN_CHANNELS,
  parameter int LANE_W      = lane_w(IN_CHANNELS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              beat_i,
  input  logic [LANE_W-1:0]                 lane_i,
  input  logic [DATA_WIDTH-1:0]             data_i,
  output logic [DATA_WIDTH*IN_CHANNELS-1:0] word_o,
  output logic                              word_done_o
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(IN_CHANNELS - 1);

  logic [DATA_WIDTH*IN_CHANNELS-1:0] pack_q, pack_d;

  // The merged word is exposed so the top can latch the complete pixel in
  // the same cycle the final lane arrives; that gives a 1-cycle write latency.
  always_comb begin
    pack_d = pack_q;
    if (beat_i) begin
      pack_d[int'(lane_i) * DATA_WIDTH +: DATA_WIDTH] = data_i;
    end
  end

  assign word_o      = pack_d;
  assign word_done_o = beat_i && (lane_i == LAST_LANE);

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q <= '0;
    end else begin
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/bram_input_1x1_loader.sv
// ---------------------------------------------------------------------------
// bram_input_1x1_loader
// Upstream stage of the 1x1-conv input feature-map BRAM. Accepts channel
// samples in channel-interleaved order, packs IN_CHANNELS of them into one
// pixel word and writes one word per pixel address. After the whole frame is
// written it raises buf_full and blocks input until the consumer releases.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : pulse, begin a frame (honoured only in IDLE)
//   buf_release   : pulse from consumer, buffer consumed (honoured only in
//                   FULL; "release" is a reserved word in SystemVerilog)
//   s_data/s_valid/s_ready : sample stream
//   s_last, err   : only with BRAM_INPUT_LOADER_LAST_CHK_EN defined; err is a
//                   sticky frame-framing error flag
//   wr_data/wr_addr/wr_en  : BRAM write port
//   buf_full      : frame complete and committed
//   busy          : high in LOAD and DRAIN
//
// Stream handshake: a sample transfers on a rising edge where s_valid and
// s_ready are both high; s_ready depends only on registered state, so it
// never depends on s_valid combinationally.
//
// Optional feature macro: BRAM_INPUT_LOADER_LAST_CHK_EN.
// ---------------------------------------------------------------------------
module bram_input_1x1_loader
  import bram_input_1x1_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int IN_CHANNELS = DEF_IN_CHANNELS,
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int IN_HEIGHT   = DEF_IN_HEIGHT
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  input  logic                                            buf_release,
  input  logic [DATA_WIDTH-1:0]                           s_data,
  input  logic                                            s_valid,
  output logic                                            s_ready,
`ifdef BRAM_INPUT_LOADER_LAST_CHK_EN
  input  logic                                            s_last,
  output logic                                            err,
`endif
  output logic [word_w(DATA_WIDTH, IN_CHANNELS)-1:0]      wr_data,
  output logic [addr_w(IN_WIDTH, IN_HEIGHT)-1:0]          wr_addr,
  output logic                                            wr_en,
  output logic                                            buf_full,
  output logic                                            busy
);

  localparam int NUM_PIXELS = IN_WIDTH * IN_HEIGHT;
  localparam int AW         = addr_w(IN_WIDTH, IN_HEIGHT);
  localparam int WW         = word_w(DATA_WIDTH, IN_CHANNELS);
  localparam int CW         = lane_w(IN_CHANNELS);

  localparam logic [CW-1:0] CH_LAST  = CW'(IN_CHANNELS - 1);
  localparam logic [AW-1:0] PIX_LAST = AW'(NUM_PIXELS - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   ch_cnt_q, ch_cnt_d;
  logic [AW-1:0]   pix_cnt_q, pix_cnt_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [WW-1:0]   wr_data_q, wr_data_d;

  logic            beat;
  logic            final_pos;
  logic [WW-1:0]   word;
  logic            word_done;

  assign beat      = s_valid && (state_q == ST_LOAD);
  assign final_pos = (ch_cnt_q == CH_LAST) && (pix_cnt_q == PIX_LAST);

  bram_input_1x1_loader_channel_packer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .IN_CHANNELS (IN_CHANNELS),
    .LANE_W      (CW)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .beat_i      (beat),
    .lane_i      (ch_cnt_q),
    .data_i      (s_data),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    pix_cnt_d = pix_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          ch_cnt_d  = '0;
          pix_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (beat) begin
          ch_cnt_d = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + CW'(1);
          if (final_pos) begin
            state_d = ST_DRAIN;
          end
        end
      end
      // The final pixel's wr_en is the registered strobe visible here.
      ST_DRAIN: state_d = ST_FULL;
      // start is ignored here, so a simultaneous release wins.
      ST_FULL: begin
        if (buf_release) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // word_done only fires on a LOAD beat, so writes cannot occur in IDLE/FULL.
    if (word_done) begin
      wr_en_d   = 1'b1;
      wr_data_d = word;
      wr_addr_d = pix_cnt_q;
      pix_cnt_d = pix_cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef BRAM_INPUT_LOADER_LAST_CHK_EN
  logic err_q, err_d;

  // s_last must be high exactly on the final frame beat; any disagreement
  // latches err until the next honoured start. Counting is unaffected.
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && start) begin
      err_d = 1'b0;
    end
    if (beat && (s_last != final_pos)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign s_ready  = (state_q == ST_LOAD);
  assign buf_full = (state_q == ST_FULL);
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_bram_input_1x1_loader.sv
// ---------------------------------------------------------------------------
// tb_bram_input_1x1_loader
// Directed bench for bram_input_1x1_loader at default geometry (8-bit samples,
// 3 channels, 5x5 pixels). Beat i carries s_data = i, so pixel k must be
// written at address k with {3k+2, 3k+1, 3k}.
// ---------------------------------------------------------------------------
module tb_bram_input_1x1_loader;

  localparam int DW = 8;
  localparam int NP = 25;
  localparam int NB = 75;
  localparam int AW = 5;
  localparam int WW = 24;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start       = 1'b0;
  logic          buf_release = 1'b0;
  logic [DW-1:0] s_data      = '0;
  logic          s_valid     = 1'b0;
  logic          s_ready;
  logic [WW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          buf_full;
  logic          busy;
`ifdef BRAM_INPUT_LOADER_LAST_CHK_EN
  logic          s_last = 1'b0;
  logic          err;
`endif

  bram_input_1x1_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .buf_release (buf_release),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
`ifdef BRAM_INPUT_LOADER_LAST_CHK_EN
    .s_last      (s_last),
    .err         (err),
`endif
    .wr_data     (wr_data),
    .wr_addr     (wr_addr),
    .wr_en       (wr_en),
    .buf_full    (buf_full),
    .busy        (busy)
  );

  int tests = 0;
  int fails = 0;

  // Scoreboard: expected words, plus a monitor capturing every write.
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] cap_data[$];
  logic [AW-1:0] cap_addr[$];
  int            accept_cnt = 0;
  int            dbl_cnt    = 0;
  logic          wr_en_prev = 1'b0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_data.push_back(wr_data);
      cap_addr.push_back(wr_addr);
      if (wr_en_prev === 1'b1) dbl_cnt++;
    end
    wr_en_prev = wr_en;
    if (s_valid && s_ready === 1'b1) accept_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_release();
    buf_release = 1'b1;
    @(posedge clk); #1;
    buf_release = 1'b0;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input bit last);
    int budget;
    budget = 50;
    s_data  = d;
    s_valid = 1'b1;
`ifdef BRAM_INPUT_LOADER_LAST_CHK_EN
    s_last  = last;
`else
    if (last) s_data = d;
`endif
    forever begin
      @(negedge clk);
      if (s_ready === 1'b1) break;
      budget--;
      if (budget == 0) begin
        tests++; fails++;
        $display("FAIL beat_timeout: beat %0d not accepted, s_ready=%b required 1", d, s_ready);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
`ifdef BRAM_INPUT_LOADER_LAST_CHK_EN
    s_last  = 1'b0;
`endif
  endtask

  task automatic send_frame(input bit gaps, input int last_idx, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) idle_cycle();
      drive_beat(DW'(i), i == last_idx);
    end
  endtask

  task automatic build_expected();
    exp_q = {};
    for (int k = 0; k < NP; k++) begin
      logic [DW-1:0] b0, b1, b2;
      b0 = DW'(3 * k);
      b1 = DW'(3 * k + 1);
      b2 = DW'(3 * k + 2);
      exp_q.push_back({b2, b1, b0});
    end
  endtask

  // After the final beat: DRAIN cycle carries the last write, FULL follows.
  task automatic finish_frame(input string name);
    @(negedge clk);
    tests++;
    if (wr_en !== 1'b1 || wr_addr !== AW'(NP - 1) || buf_full !== 1'b0 ||
        s_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_drain: wr_en=%b addr=%0d buf_full=%b s_ready=%b busy=%b required 1 24 0 0 1",
               name, wr_en, wr_addr, buf_full, s_ready, busy);
    end
    @(negedge clk);
    tests++;
    if (buf_full !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0 ||
        wr_data !== 24'h4A4948 || wr_addr !== AW'(NP - 1)) begin
      fails++;
      $display("FAIL %s_full: buf_full=%b busy=%b wr_en=%b data=%h addr=%0d required 1 0 0 4a4948 24",
               name, buf_full, busy, wr_en, wr_data, wr_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string name, input int base);
    build_expected();
    tests++;
    if (cap_data.size() - base != NP) begin
      fails++;
      $display("FAIL %s_count: %0d writes, required %0d", name, cap_data.size() - base, NP);
    end
    for (int k = 0; k < NP && base + k < cap_data.size(); k++) begin
      tests++;
      if (cap_addr[base + k] !== AW'(k) || cap_data[base + k] !== exp_q[k]) begin
        fails++;
        $display("FAIL %s_word%0d: addr=%0d data=%h required addr=%0d data=%h",
                 name, k, cap_addr[base + k], cap_data[base + k], k, exp_q[k]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int base;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (s_ready !== 1'b0 || wr_en !== 1'b0 || buf_full !== 1'b0 || busy !== 1'b0 ||
        wr_addr !== '0 || wr_data !== '0) begin
      fails++;
      $display("FAIL reset_values: s_ready=%b wr_en=%b buf_full=%b busy=%b addr=%0d data=%h required all 0",
               s_ready, wr_en, buf_full, busy, wr_addr, wr_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    base = cap_data.size();
    s_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    s_valid = 1'b0;
    tests++;
    if (cap_data.size() != base || s_ready !== 1'b0 || buf_full !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_start: writes=%0d s_ready=%b buf_full=%b busy=%b required 0 0 0 0",
               cap_data.size() - base, s_ready, buf_full, busy);
    end
  endtask

  task automatic test_back_to_back();
    int  base;
    time t0;
    base = cap_data.size();
    pulse_start();
    tests++;
    if (s_ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL load_entry: s_ready=%b busy=%b required 1 1", s_ready, busy);
    end
    t0 = $time;
    send_frame(1'b0, NB - 1, NB);
    tests++;
    if (($time - t0) / 10 != NB) begin
      fails++;
      $display("FAIL throughput: %0d cycles for %0d beats, required %0d", ($time - t0) / 10, NB, NB);
    end
    finish_frame("b2b");
    check_frame("b2b", base);
  endtask

  task automatic test_full();
    int base, acc0;
    base = cap_data.size();
    acc0 = accept_cnt;
    for (int i = 0; i < NB; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i);
      start   = (i == 10);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    tests++;
    if (accept_cnt != acc0 || cap_data.size() != base || buf_full !== 1'b1) begin
      fails++;
      $display("FAIL full_hold: accepts=%0d writes=%0d buf_full=%b required 0 0 1",
               accept_cnt - acc0, cap_data.size() - base, buf_full);
    end
    // Simultaneous start and release: release wins, start dropped.
    start = 1'b1;
    buf_release = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    buf_release = 1'b0;
    @(negedge clk);
    tests++;
    if (buf_full !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL release_wins: buf_full=%b s_ready=%b busy=%b required 0 0 0",
               buf_full, s_ready, busy);
    end
    @(posedge clk); #1;
    base = cap_data.size();
    pulse_start();
    send_frame(1'b0, NB - 1, NB);
    finish_frame("restart");
    check_frame("restart", base);
  endtask

  task automatic test_gaps();
    int base, dbl0;
    pulse_release();
    base = cap_data.size();
    dbl0 = dbl_cnt;
    pulse_start();
    send_frame(1'b1, NB - 1, NB);
    finish_frame("gaps");
    check_frame("gaps", base);
    tests++;
    if (dbl_cnt != dbl0) begin
      fails++;
      $display("FAIL gaps_single_strobe: %0d multi-cycle wr_en, required 0", dbl_cnt - dbl0);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    pulse_release();
    pulse_start();
    send_frame(1'b0, -1, 40);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (s_ready !== 1'b0 || wr_en !== 1'b0 || buf_full !== 1'b0 || busy !== 1'b0 ||
        wr_addr !== '0 || wr_data !== '0) begin
      fails++;
      $display("FAIL reset_mid: s_ready=%b wr_en=%b buf_full=%b busy=%b addr=%0d data=%h required all 0",
               s_ready, wr_en, buf_full, busy, wr_addr, wr_data);
    end
    @(posedge clk); #1;
    base = cap_data.size();
    pulse_start();
    send_frame(1'b0, NB - 1, NB);
    finish_frame("after_rst");
    check_frame("after_rst", base);
  endtask

`ifdef BRAM_INPUT_LOADER_LAST_CHK_EN
  task automatic test_last_chk();
    int base;
    pulse_release();
    base = cap_data.size();
    pulse_start();
    send_frame(1'b0, 30, NB);
    finish_frame("early_last");
    check_frame("early_last", base);
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL err_early_last: err=%b required 1", err);
    end
    pulse_release();
    pulse_start();
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear_on_start: err=%b required 0", err);
    end
    send_frame(1'b0, NB - 1, NB);
    finish_frame("good_last");
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_good_last: err=%b required 0", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_gaps();
    test_reset_mid();
`ifdef BRAM_INPUT_LOADER_LAST_CHK_EN
    test_last_chk();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
